// File: rtl/weight23_pkg.sv
// Shared types and code-table helpers for the 2-of-4/3-of-4 serial transmitter.
package weight23_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int NUM_CODES = 10;

  function automatic logic is_legal_idx(input logic [3:0] idx);
    return idx < 4'(NUM_CODES);
  endfunction

  // Ascending enumeration of every 4-bit word with popcount 2 or 3.
  function automatic logic [3:0] idx_to_code(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'b0011;
      4'd1:    code = 4'b0101;
      4'd2:    code = 4'b0110;
      4'd3:    code = 4'b0111;
      4'd4:    code = 4'b1001;
      4'd5:    code = 4'b1010;
      4'd6:    code = 4'b1011;
      4'd7:    code = 4'b1100;
      4'd8:    code = 4'b1101;
      4'd9:    code = 4'b1110;
      default: code = 4'b0000;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/weight23_tx_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 and flags the terminal count.
module bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Clearing on accept aligns the first bit period with the start bit.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == TERM) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == TERM);

endmodule

// File: rtl/weight23_tx.sv
// Framed serial transmitter: index 0..9 -> weight-2/3 codeword, sent LSB first
// between a low start bit and a high stop bit.
module weight23_tx
  import weight23_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       err_o
);

  state_t     state, next_state;
  logic [3:0] sreg, sreg_next;
  logic [1:0] bit_idx, bit_idx_next;
  logic       tx_next, err_next;
  logic       accept, tick;

  assign accept = valid_i && ready_o;

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(accept),
    .tick (tick)
  );

  always_comb begin
    next_state   = state;
    sreg_next    = sreg;
    bit_idx_next = bit_idx;
    err_next     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_legal_idx(data_i)) begin
            next_state   = START;
            sreg_next    = idx_to_code(data_i);
            bit_idx_next = 2'd0;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      START: if (tick) next_state = DATA;
      DATA: begin
        if (tick) begin
          sreg_next = {1'b0, sreg[3:1]};
          if (bit_idx == 2'd3) begin
            next_state = STOP;
          end else begin
            bit_idx_next = bit_idx + 2'd1;
          end
        end
      end
      STOP: if (tick) next_state = IDLE;
      default: next_state = IDLE;
    endcase

    // Line level is computed from the state being entered so tx_o is registered.
    case (next_state)
      START:   tx_next = 1'b0;
      DATA:    tx_next = sreg_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_idx <= '0;
      tx_o    <= 1'b1;
      ready_o <= 1'b1;
      busy_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      state   <= next_state;
      sreg    <= sreg_next;
      bit_idx <= bit_idx_next;
      tx_o    <= tx_next;
      ready_o <= (next_state == IDLE);
      busy_o  <= (next_state != IDLE);
      err_o   <= err_next;
    end
  end

endmodule

// File: tb/tb_weight23_tx.sv
// Directed bench for weight23_tx at BIT_CYCLES = 4 and BIT_CYCLES = 1.
module tb_weight23_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data4, data1;
  logic       valid4, valid1;
  logic       rdy4, tx4, busy4, err4;
  logic       rdy1, tx1, busy1, err1;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_acc = 0;

  logic [3:0] code_tab [10] = '{4'b0011, 4'b0101, 4'b0110, 4'b0111, 4'b1001,
                                4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  weight23_tx #(.BIT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .data_i(data4), .valid_i(valid4),
    .ready_o(rdy4), .tx_o(tx4), .busy_o(busy4), .err_o(err4)
  );

  weight23_tx #(.BIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .data_i(data1), .valid_i(valid1),
    .ready_o(rdy1), .tx_o(tx1), .busy_o(busy1), .err_o(err1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Offer idx, wait for the accept, then follow the whole frame cycle by cycle.
  task automatic send_frame(input bit one, input logic [3:0] idx, input logic [3:0] code,
                            input bit hold);
    int         bc;
    int         n;
    logic [3:0] rx;
    logic       exp_b;
    logic       tx_s;
    bc = one ? 1 : 4;
    n  = 0;
    rx = 4'b0000;
    if (one) begin data1 = idx; valid1 = 1'b1; end
    else     begin data4 = idx; valid4 = 1'b1; end
    while (!(one ? rdy1 : rdy4) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ready_before_accept_%0d", idx), one ? rdy1 : rdy4, 1);
    last_acc = cyc;
    @(negedge clk);
    if (!hold) begin
      if (one) valid1 = 1'b0; else valid4 = 1'b0;
    end
    check($sformatf("busy_in_frame_%0d", idx), one ? busy1 : busy4, 1);
    check($sformatf("ready_in_frame_%0d", idx), one ? rdy1 : rdy4, 0);
    check($sformatf("err_in_frame_%0d", idx), one ? err1 : err4, 0);
    for (int b = 0; b < 6; b++) begin
      for (int c = 0; c < bc; c++) begin
        exp_b = (b == 0) ? 1'b0 : (b == 5) ? 1'b1 : code[b-1];
        tx_s  = one ? tx1 : tx4;
        check($sformatf("tx_idx%0d_bit%0d_cyc%0d", idx, b, c), tx_s, exp_b);
        if (c == 0 && b >= 1 && b <= 4) rx[b-1] = tx_s;
        @(negedge clk);
      end
    end
    check($sformatf("ready_after_frame_%0d", idx), one ? rdy1 : rdy4, 1);
    check($sformatf("busy_after_frame_%0d", idx), one ? busy1 : busy4, 0);
    check($sformatf("rx_code_%0d", idx), rx, code);
    check($sformatf("weight_ok_%0d", idx),
          ($countones(rx) == 2 || $countones(rx) == 3) ? 1 : 0, 1);
  endtask

  initial begin
    int prev;
    rst = 1'b1;
    valid4 = 1'b0; valid1 = 1'b0;
    data4 = 4'd0;  data1 = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx4, 1);
    check("rst_ready", rdy4, 1);
    check("rst_busy", busy4, 0);
    check("rst_err", err4, 0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_tx", tx4, 1);
      check("idle_ready", rdy4, 1);
      check("idle_busy", busy4, 0);
      check("idle_err", err4, 0);
      check("idle_tx_b1", tx1, 1);
      check("idle_busy_b1", busy1, 0);
    end

    send_frame(1'b0, 4'd0, code_tab[0], 1'b0);
    repeat (2) @(negedge clk);

    prev = 0;
    for (int i = 0; i < 10; i++) begin
      send_frame(1'b0, 4'(i), code_tab[i], 1'b1);
      if (i > 0) check($sformatf("accept_spacing_%0d", i), last_acc - prev, 25);
      prev = last_acc;
    end
    valid4 = 1'b0;
    repeat (2) @(negedge clk);

    data4 = 4'd12; valid4 = 1'b1;
    @(negedge clk);
    check("illegal_err", err4, 1);
    check("illegal_tx", tx4, 1);
    check("illegal_busy", busy4, 0);
    check("illegal_ready", rdy4, 1);
    send_frame(1'b0, 4'd1, code_tab[1], 1'b0);
    repeat (2) @(negedge clk);

    data4 = 4'd9; valid4 = 1'b1;
    @(negedge clk);
    valid4 = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_frame_tx_bit1", tx4, 1);
    check("mid_frame_busy", busy4, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_tx", tx4, 1);
    check("abort_ready", rdy4, 1);
    check("abort_busy", busy4, 0);
    @(negedge clk);
    check("abort_no_resume_busy", busy4, 0);
    check("abort_no_resume_tx", tx4, 1);
    send_frame(1'b0, 4'd4, code_tab[4], 1'b0);

    send_frame(1'b1, 4'd6, code_tab[6], 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
